// File: rtl/conv_pkg.sv
// Shared constants and sequencer state encoding for the 5x5 convolution patch path.
package conv_pkg;
    localparam int PATCH_DIM           = 5;
    localparam int INPUT_WIDTH         = 8;
    localparam int OUTPUT_WIDTH        = 16;
    localparam int NUM_KERNEL_ELEMENTS = 25;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        KICK,
        WAIT_CORE,
        EMIT,
        DONE
    } seq_state_e;
endpackage

// File: rtl/conv_addr_gen.sv
// Patch origin (ox,oy) and in-patch (r,c) counters; forms the row-major pixel address.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [4:0]        k_o,
    output logic              fetch_last_o,
    output logic              pos_last_o
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [2:0]    r_q, r_d, c_q, c_d;

    assign fetch_last_o = (r_q == 3'(PATCH_DIM - 1)) && (c_q == 3'(PATCH_DIM - 1));
    assign pos_last_o   = (ox_q == XW'(IMG_W - PATCH_DIM)) && (oy_q == YW'(IMG_H - PATCH_DIM));
    assign k_o          = {2'b00, r_q} * 5'(PATCH_DIM) + {2'b00, c_q};
    assign rd_addr_o    = (ADDR_W'(oy_q) + ADDR_W'(r_q)) * ADDR_W'(IMG_W)
                        + ADDR_W'(ox_q) + ADDR_W'(c_q);

    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        r_d  = r_q;
        c_d  = c_q;
        if (clear_i) begin
            ox_d = '0;
            oy_d = '0;
            r_d  = '0;
            c_d  = '0;
        end else begin
            // r/c wrap back to 0 after the 25th read, ready for the next patch
            if (step_i) begin
                if (c_q == 3'(PATCH_DIM - 1)) begin
                    c_d = '0;
                    r_d = (r_q == 3'(PATCH_DIM - 1)) ? 3'd0 : r_q + 3'd1;
                end else begin
                    c_d = c_q + 3'd1;
                end
            end
            if (advance_i) begin
                if (ox_q == XW'(IMG_W - PATCH_DIM)) begin
                    ox_d = '0;
                    oy_d = oy_q + YW'(1);
                end else begin
                    ox_d = ox_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox_q <= '0;
            oy_q <= '0;
            r_q  <= '0;
            c_q  <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
            r_q  <= r_d;
            c_q  <= c_d;
        end
    end
endmodule

// File: rtl/conv_patch_sequencer.sv
// Walks the image in raster order, fetches each 5x5 patch, kicks the conv core and streams results.
// Optional busy-cycle counter on perf_cycles is built only when CONV_SEQ_PERF_EN is defined.
module conv_patch_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       rd_en,
    output logic [ADDR_W-1:0]                          rd_addr,
    input  logic [INPUT_WIDTH-1:0]                     rd_data,
    output logic                                       start_channel_proc,
    output logic [NUM_KERNEL_ELEMENTS*INPUT_WIDTH-1:0] patch_pixels,
    input  logic                                       core_busy,
    input  logic                                       core_valid,
    input  logic signed [OUTPUT_WIDTH-1:0]             core_value,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUTPUT_WIDTH-1:0]                    out_data,
    output logic                                       out_last,
    output logic [31:0]                                perf_cycles
);
    seq_state_e state_q, state_d;

    logic pos_clear, fetch_step, pos_adv;
    logic [4:0] k, rd_k_q;
    logic fetch_last, pos_last;
    logic rd_vld_q;

    logic [NUM_KERNEL_ELEMENTS-1:0][INPUT_WIDTH-1:0] patch_q;
    logic                    out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    conv_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (pos_clear),
        .step_i      (fetch_step),
        .advance_i   (pos_adv),
        .rd_addr_o   (rd_addr),
        .k_o         (k),
        .fetch_last_o(fetch_last),
        .pos_last_o  (pos_last)
    );

    assign busy               = (state_q != IDLE);
    assign done               = (state_q == DONE);
    assign rd_en              = (state_q == FETCH);
    assign start_channel_proc = (state_q == KICK) && !core_busy;
    assign patch_pixels       = patch_q;
    assign out_valid          = out_valid_q;
    assign out_data           = out_data_q;
    assign out_last           = out_last_q;

    always_comb begin
        state_d     = state_q;
        pos_clear   = 1'b0;
        fetch_step  = 1'b0;
        pos_adv     = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = FETCH;
                pos_clear = 1'b1;
            end
            FETCH: begin
                fetch_step = 1'b1;
                if (fetch_last) state_d = DRAIN;
            end
            DRAIN: state_d = KICK;
            KICK: if (!core_busy) state_d = WAIT_CORE;
            WAIT_CORE: if (core_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = core_value;
                out_last_d  = pos_last;
                state_d     = EMIT;
            end
            EMIT: if (out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (pos_last) begin
                    state_d = DONE;
                end else begin
                    pos_adv = 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory latency is one cycle, so the element index travels one stage behind the read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_vld_q    <= 1'b0;
            rd_k_q      <= '0;
            patch_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_vld_q    <= rd_en;
            rd_k_q      <= k;
            if (rd_vld_q) patch_q[rd_k_q] <= rd_data;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_q <= '0;
        end else if (busy && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif
endmodule
